// File: rtl/permute_issue.sv
// SPU permute-pipe decode/issue stage with a shift-register write scoreboard.
// Optional stall counter output enabled by PERMUTE_ISSUE_STATS_EN.
module permute_issue #(
  parameter int PEND_DEPTH = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid,
  input  logic [0:31]  instr,
  output logic         instr_ready,
  output logic [0:6]   ra_addr,
  output logic [0:6]   rb_addr,
  input  logic [0:127] ra_data,
  input  logic [0:127] rb_data,
  output logic [0:10]  op,
  output logic [2:0]   format,
  output logic [0:6]   rt_addr,
  output logic [0:127] ra,
  output logic [0:127] rb,
  output logic [0:17]  imm,
  output logic         reg_write
`ifdef PERMUTE_ISSUE_STATS_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    C_ILL,
    C_RR,
    C_GB,
    C_RI7
  } cls_e;

  logic [0:10] opc11;
  logic [0:6]  f_rb;
  logic [0:6]  f_ra;
  logic [0:6]  f_rt;
  cls_e        cls;
  logic        use_a;
  logic        use_b;
  logic        hazard;
  logic        issue;

  assign opc11 = instr[0:10];
  assign f_rb  = instr[11:17];
  assign f_ra  = instr[18:24];
  assign f_rt  = instr[25:31];

  assign ra_addr = f_ra;
  assign rb_addr = f_rb;

  always_comb begin
    cls = C_ILL;
    unique case (opc11)
      11'b00111011011,
      11'b00111011111,
      11'b00111011000,
      11'b00111011100: cls = C_RR;
      11'b00110110010,
      11'b00110110001,
      11'b00110110000: cls = C_GB;
      11'b00111111011,
      11'b00111111111,
      11'b00111111000,
      11'b00111111100: cls = C_RI7;
      default:         cls = C_ILL;
    endcase
  end

  assign use_a = (cls != C_ILL);
  assign use_b = (cls == C_RR);

  logic       sb_v_q [PEND_DEPTH];
  logic [6:0] sb_a_q [PEND_DEPTH];

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (sb_v_q[i]) begin
        if (use_a && sb_a_q[i] == f_ra) hazard = 1'b1;
        if (use_b && sb_a_q[i] == f_rb) hazard = 1'b1;
      end
    end
  end

  // Ready deliberately ignores instr_valid.
  assign instr_ready = !reset && !hazard;
  assign issue = instr_valid && instr_ready;

  logic [0:10]  op_d, op_q;
  logic [2:0]   fmt_d, fmt_q;
  logic [0:6]   rt_d, rt_q;
  logic [0:127] ra_d, ra_q;
  logic [0:127] rb_d, rb_q;
  logic [0:17]  imm_d, imm_q;
  logic         we_d, we_q;

  always_comb begin
    op_d  = '0;
    fmt_d = '0;
    rt_d  = '0;
    ra_d  = '0;
    rb_d  = '0;
    imm_d = '0;
    we_d  = 1'b0;
    if (issue && cls != C_ILL) begin
      op_d = opc11;
      rt_d = f_rt;
      ra_d = ra_data;
      we_d = 1'b1;
      if (cls == C_RI7) begin
        fmt_d = 3'd2;
        imm_d = {11'b0, f_rb};
      end else begin
        rb_d = rb_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      fmt_q <= '0;
      rt_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
      we_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      fmt_q <= fmt_d;
      rt_q  <= rt_d;
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      imm_q <= imm_d;
      we_q  <= we_d;
    end
  end

  // Oldest entry falls off the end; nops shift in an invalid slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PEND_DEPTH; i++) begin
        sb_v_q[i] <= 1'b0;
        sb_a_q[i] <= '0;
      end
    end else begin
      sb_v_q[0] <= we_d;
      sb_a_q[0] <= rt_d;
      for (int i = 1; i < PEND_DEPTH; i++) begin
        sb_v_q[i] <= sb_v_q[i-1];
        sb_a_q[i] <= sb_a_q[i-1];
      end
    end
  end

  assign op        = op_q;
  assign format    = fmt_q;
  assign rt_addr   = rt_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign imm       = imm_q;
  assign reg_write = we_q;

`ifdef PERMUTE_ISSUE_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (instr_valid && !instr_ready
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_permute_issue.sv
// Bench for permute_issue: directed table, dependency/reset
// sequences and randomized traffic against a per-register model.
module tb_permute_issue;

  localparam int PEND = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         instr_valid;
  logic [0:31]  instr;
  logic         instr_ready;
  logic [0:6]   ra_addr, rb_addr;
  logic [0:127] ra_data, rb_data;
  logic [0:10]  op;
  logic [2:0]   format;
  logic [0:6]   rt_addr;
  logic [0:127] ra, rb;
  logic [0:17]  imm;
  logic         reg_write;
`ifdef PERMUTE_ISSUE_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  permute_issue #(.PEND_DEPTH(PEND)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .op(op), .format(format), .rt_addr(rt_addr),
    .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write)
`ifdef PERMUTE_ISSUE_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [0:127] rf [128];
  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];

  localparam logic [10:0] SHLQBI  = 11'b00111011011;
  localparam logic [10:0] SHLQBY  = 11'b00111011111;
  localparam logic [10:0] ROTQBI  = 11'b00111011000;
  localparam logic [10:0] ROTQBY  = 11'b00111011100;
  localparam logic [10:0] GBB     = 11'b00110110010;
  localparam logic [10:0] GBH     = 11'b00110110001;
  localparam logic [10:0] GB      = 11'b00110110000;
  localparam logic [10:0] SHLQBII = 11'b00111111011;
  localparam logic [10:0] SHLQBYI = 11'b00111111111;
  localparam logic [10:0] ROTQBII = 11'b00111111000;
  localparam logic [10:0] ROTQBYI = 11'b00111111100;
  localparam logic [10:0] ILLOP   = 11'b11111111111;

  int n_pass = 0;
  int n_tot  = 0;
  int edge_n = 0;
  int lastw [128];
  int stall_exp = 0;
  bit last_ready;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [0:31] mk(input logic [10:0] o,
      input logic [6:0] b, input logic [6:0] a, input logic [6:0] t);
    return {o, b, a, t};
  endfunction

  // 0 illegal, 1 RR (RA+RB), 2 gb* (RA), 3 RI7 (RA)
  function automatic int cls_of(input logic [10:0] o);
    if (o == SHLQBI || o == SHLQBY || o == ROTQBI || o == ROTQBY)
      return 1;
    if (o == GBB || o == GBH || o == GB) return 2;
    if (o == SHLQBII || o == SHLQBYI || o == ROTQBII || o == ROTQBYI)
      return 3;
    return 0;
  endfunction

  // A write accepted at edge W blocks reads at any edge E with E-W<=PEND.
  function automatic bit haz(input logic [0:31] ins);
    int c;
    int e;
    bit h;
    c = cls_of(ins[0:10]);
    e = edge_n + 1;
    h = 1'b0;
    if (c != 0 && e - lastw[ins[18:24]] <= PEND) h = 1'b1;
    if (c == 1 && e - lastw[ins[11:17]] <= PEND) h = 1'b1;
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) lastw[i] = -1000;
  endtask

  task automatic step(input bit v, input logic [0:31] ins);
    int c;
    bit hz, iss;
    logic [0:127] era, erb;
    c = cls_of(ins[0:10]);
    instr_valid = v;
    instr = ins;
    #1;
    hz = haz(ins);
    last_ready = instr_ready;
    chk("ready", instr_ready, !hz);
    iss = v && !hz;
    if (v && hz) stall_exp++;
    era = rf[ins[18:24]];
    erb = rf[ins[11:17]];
    @(posedge clk);
    edge_n++;
    #1;
    if (iss && c != 0) begin
      lastw[ins[25:31]] = edge_n;
      chk("op", op, ins[0:10]);
      chk("format", format, (c == 3) ? 3'd2 : 3'd0);
      chk("rt_addr", rt_addr, ins[25:31]);
      chk("reg_write", reg_write, 1'b1);
      chk("ra", ra, era);
      if (c == 3) chk("rb", rb, 128'h0);
      else if (c == 1) chk("rb", rb, erb);
      chk("imm", imm, (c == 3) ? {11'b0, ins[11:17]} : 18'h0);
    end else begin
      chk("nop_op", op, 11'h0);
      chk("nop_fmt", format, 3'd0);
      chk("nop_rt", rt_addr, 7'h0);
      chk("nop_we", reg_write, 1'b0);
      chk("nop_ra", ra, 128'h0);
      chk("nop_rb", rb, 128'h0);
      chk("nop_imm", imm, 18'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  typedef struct {
    logic [0:31]  ins;
    logic [0:10]  op;
    logic [2:0]   fmt;
    logic [0:6]   rt;
    logic [0:17]  imm;
    logic         we;
    logic [0:127] ra;
    logic [0:127] rb;
  } vec_t;

  vec_t tbl [6];
  logic [10:0] ops [12];

  initial begin
    logic [0:31] prod, cons;
    int stalls;
    bit acc;

    for (int i = 0; i < 128; i++)
      rf[i] = {$urandom, $urandom, $urandom, $urandom};
    rf[1] = 128'h1;
    rf[2] = 128'h3;
    model_clear();

    tbl[0] = '{mk(SHLQBI, 7'd2, 7'd1, 7'd5), SHLQBI, 3'd0, 7'd5,
               18'h0, 1'b1, 128'h1, 128'h3};
    tbl[1] = '{mk(ROTQBYI, 7'h13, 7'd4, 7'd9), ROTQBYI, 3'd2, 7'd9,
               18'h13, 1'b1, rf[4], 128'h0};
    tbl[2] = '{mk(ILLOP, 7'd3, 7'd3, 7'd50), 11'h0, 3'd0, 7'd0,
               18'h0, 1'b0, 128'h0, 128'h0};
    tbl[3] = '{mk(ROTQBI, 7'd126, 7'd127, 7'd0), ROTQBI, 3'd0, 7'd0,
               18'h0, 1'b1, rf[127], rf[126]};
    tbl[4] = '{mk(SHLQBYI, 7'h7f, 7'd3, 7'd7), SHLQBYI, 3'd2, 7'd7,
               18'h7f, 1'b1, rf[3], 128'h0};
    tbl[5] = '{mk(GBH, 7'd2, 7'd1, 7'd3), GBH, 3'd0, 7'd3,
               18'h0, 1'b1, 128'h1, 128'h3};

    ops = '{SHLQBI, SHLQBY, ROTQBI, ROTQBY, GBB, GBH, GB,
            SHLQBII, SHLQBYI, ROTQBII, ROTQBYI, ILLOP};

    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    #3;
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_op", op, 11'h0);
    chk("rst_we", reg_write, 1'b0);
    chk("rst_ra", ra, 128'h0);
`ifdef PERMUTE_ISSUE_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 16'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 6; i++) begin
      idle(PEND + 2);
      step(1'b1, tbl[i].ins);
      chk("tbl_ready", last_ready, 1'b1);
      chk("tbl_op", op, tbl[i].op);
      chk("tbl_fmt", format, tbl[i].fmt);
      chk("tbl_rt", rt_addr, tbl[i].rt);
      chk("tbl_imm", imm, tbl[i].imm);
      chk("tbl_we", reg_write, tbl[i].we);
      chk("tbl_ra", ra, tbl[i].ra);
      if (i != 5) chk("tbl_rb", rb, tbl[i].rb);
      if (i == 2) begin
        step(1'b1, mk(SHLQBI, 7'd1, 7'd50, 7'd51));
        chk("after_illegal_ready", last_ready, 1'b1);
      end
    end

    idle(PEND + 2);
    prod = mk(SHLQBY, 7'd12, 7'd11, 7'd10);
    cons = mk(SHLQBI, 7'd13, 7'd10, 7'd20);
    step(1'b1, prod);
    stalls = 0;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1'b1, cons);
      if (last_ready) acc = 1'b1;
      else stalls++;
    end
    chk("dep_accepted", acc, 1'b1);
    chk("dep_stalls", stalls, 6);
`ifdef PERMUTE_ISSUE_STATS_EN
    chk("dep_stall_cnt", stall_cnt, 16'd6);
`endif

    idle(PEND + 2);
    step(1'b1, mk(SHLQBI, 7'd2, 7'd1, 7'd30));
    step(1'b1, mk(ROTQBI, 7'd4, 7'd3, 7'd30));
    chk("waw_ready", last_ready, 1'b1);
    idle(PEND + 2);
    step(1'b1, mk(ROTQBY, 7'd40, 7'd40, 7'd40));
    chk("self_ready", last_ready, 1'b1);
    idle(PEND + 2);
    step(1'b1, mk(SHLQBI, 7'd1, 7'd2, 7'd60));
    idle(2);
    step(1'b1, mk(ROTQBII, 7'd5, 7'd3, 7'd60));
    stalls = 0;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1'b1, mk(GB, 7'd0, 7'd60, 7'd61));
      if (last_ready) acc = 1'b1;
      else stalls++;
    end
    chk("dbl_stalls", stalls, 6);

    for (int n = 0; n < 400; n++) begin
      logic [10:0] o;
      o = ($urandom_range(0, 7) == 0) ? 11'($urandom)
          : ops[$urandom_range(0, 11)];
      step($urandom_range(0, 4) != 0,
           mk(o, 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
              7'($urandom_range(0, 7))));
    end
`ifdef PERMUTE_ISSUE_STATS_EN
    chk("rand_stall_cnt", stall_cnt, 16'(stall_exp));
`endif

    idle(PEND + 2);
    step(1'b1, prod);
    step(1'b1, cons);
    step(1'b1, cons);
    chk("pre_rst_stall", last_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_ready", instr_ready, 1'b0);
    chk("midrst_op", op, 11'h0);
    chk("midrst_we", reg_write, 1'b0);
`ifdef PERMUTE_ISSUE_STATS_EN
    chk("midrst_stall_cnt", stall_cnt, 16'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    stall_exp = 0;
    step(1'b1, cons);
    chk("post_rst_ready", last_ready, 1'b1);
`ifdef PERMUTE_ISSUE_STATS_EN
    chk("post_rst_stall_cnt", stall_cnt, 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
